// File: rtl/circ_pkg.sv
// Shared opcodes, error bit indices and issuer FSM states for the calculator front-end.
package circ_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_MOD  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_LAST = OP_XOR;

  localparam int ERR_DIV0 = 0;
  localparam int ERR_OVF  = 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic op_known(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, datapath and result channels of the issuer; master = issuer side.
interface alu_cmd_issuer_if #(parameter int WIDTH = 16) ();

  logic               cmd_valid;
  logic               cmd_ready;
  logic [3:0]         cmd_op;
  logic [WIDTH-1:0]   cmd_a;
  logic [WIDTH-1:0]   cmd_b;

  logic [WIDTH-1:0]   alu_in1;
  logic [WIDTH-1:0]   alu_in2;
  logic [3:0]         alu_op;
  logic [2*WIDTH-1:0] alu_out;
  logic [1:0]         alu_err;

  logic               res_valid;
  logic               res_ready;
  logic [2*WIDTH-1:0] res_data;
  logic [1:0]         res_err;
  logic [3:0]         res_op;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, alu_err, res_ready,
    output cmd_ready, alu_in1, alu_in2, alu_op, res_valid, res_data, res_err, res_op
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_out, alu_err, res_ready,
    input  cmd_ready, alu_in1, alu_in2, alu_op, res_valid, res_data, res_err, res_op
  );

endinterface

// File: rtl/circ_cmd_fifo.sv
// Synchronous command FIFO with show-ahead head; writes are refused when full (no pop bypass).
module circ_cmd_fifo #(
  parameter int DW    = 36,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [DW-1:0] mem_q [DEPTH];
  logic          push, pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign push      = wr_en_i && !full_o;
  assign pop       = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues queued commands to the combinational calculator and returns captured results in order.
// Optional macro ISSUER_OPCHECK_EN: unknown opcodes are answered with an error instead of issued.
//   state | meaning
//   IDLE  | waiting for a queued command; pops and issues the head
//   WAIT  | datapath settling; counter runs down, result captured at 1
//   RESP  | result held on RES_* until accepted
module alu_cmd_issuer
  import circ_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  alu_cmd_issuer_if.master  bus
);

  localparam int DW = 4 + 2*WIDTH;
  localparam int CW = $clog2(LAT + 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   alu_in1_q, alu_in1_d, alu_in2_q, alu_in2_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic               res_valid_q, res_valid_d;
  logic [2*WIDTH-1:0] res_data_q, res_data_d;
  logic [1:0]         res_err_q, res_err_d;
  logic [3:0]         res_op_q, res_op_d;
  logic               rdy_en_q;
`ifdef ISSUER_OPCHECK_EN
  logic               bad_q, bad_d;
  logic [3:0]         cur_op_q, cur_op_d;
`endif

  logic          fifo_full, fifo_empty, fifo_pop;
  logic [DW-1:0] head;
  logic [3:0]    head_op;

  // Held low through reset and for the first edge after release.
  assign bus.cmd_ready = rdy_en_q && !fifo_full;
  assign head_op       = head[DW-1 -: 4];

  circ_cmd_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (bus.cmd_valid && bus.cmd_ready),
    .wr_data_i ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
    .rd_en_i   (fifo_pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_in1_d   = alu_in1_q;
    alu_in2_d   = alu_in2_q;
    alu_op_d    = alu_op_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_op_d    = res_op_q;
    fifo_pop    = 1'b0;
`ifdef ISSUER_OPCHECK_EN
    bad_d       = bad_q;
    cur_op_d    = cur_op_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = WAIT;
`ifdef ISSUER_OPCHECK_EN
          cur_op_d = head_op;
          if (!op_known(head_op)) begin
            bad_d = 1'b1;
            cnt_d = CW'(1);
          end else begin
            bad_d     = 1'b0;
            cnt_d     = CW'(LAT);
            alu_op_d  = head_op;
            alu_in1_d = head[2*WIDTH-1 -: WIDTH];
            alu_in2_d = head[WIDTH-1:0];
          end
`else
          cnt_d     = CW'(LAT);
          alu_op_d  = head_op;
          alu_in1_d = head[2*WIDTH-1 -: WIDTH];
          alu_in2_d = head[WIDTH-1:0];
`endif
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          res_valid_d = 1'b1;
          state_d     = RESP;
`ifdef ISSUER_OPCHECK_EN
          res_op_d = cur_op_q;
          if (bad_q) begin
            res_data_d = '0;
            res_err_d  = 2'b11;
          end else begin
            res_data_d = bus.alu_out;
            res_err_d  = bus.alu_err;
          end
`else
          res_op_d   = alu_op_q;
          res_data_d = bus.alu_out;
          res_err_d  = bus.alu_err;
`endif
        end
      end
      RESP: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      alu_op_q    <= OP_NOP;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= '0;
      res_op_q    <= '0;
      rdy_en_q    <= 1'b0;
`ifdef ISSUER_OPCHECK_EN
      bad_q       <= 1'b0;
      cur_op_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_in1_q   <= alu_in1_d;
      alu_in2_q   <= alu_in2_d;
      alu_op_q    <= alu_op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_op_q    <= res_op_d;
      rdy_en_q    <= 1'b1;
`ifdef ISSUER_OPCHECK_EN
      bad_q       <= bad_d;
      cur_op_q    <= cur_op_d;
`endif
    end
  end

  assign bus.alu_in1   = alu_in1_q;
  assign bus.alu_in2   = alu_in2_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign bus.res_op    = res_op_q;

endmodule
